// File: rtl/lim_dec_countdown.sv
// -----------------------------------------------------------------------------
// lim_dec_countdown
//
// Purpose:
//   Four-digit mm:ss countdown timer built from a chain of limited
//   decrementors. Each digit counts down modulo its own limit and borrows
//   from the next digit up. It shares the stopwatch's 1 Hz tick enable, drives
//   the 4 x 4-bit 7-segment display path, and flags expiry to the control
//   logic.
//
// Parameters:
//   L0..L3  limit of each digit (2..16). The digit's legal range is 0..Lx-1.
//
// Ports:
//   clk         in   1   system clock, rising-edge
//   reset       in   1   synchronous, active-high reset (overrides everything)
//   tick        in   1   one-cycle count enable (1 Hz strobe)
//   load        in   1   load the clamped preset and return to IDLE
//   preset      in  16   {d3,d2,d1,d0}, d0 = [3:0]
//   start_stop  in   1   one-cycle pulse that toggles run/pause
//   digits      out 16   current count {d3,d2,d1,d0}, registered
//   running     out  1   high while in RUN
//   done        out  1   one-cycle pulse on the edge where the count hits 0000
//   expired     out  1   high while in EXPIRED
//
// Configuration:
//   LIM_DEC_AUTO_RELOAD_EN - when defined, a shadow register keeps the last
//   loaded (clamped) preset. On expiry the count reloads from it and the
//   timer keeps running, so EXPIRED is never entered.
// -----------------------------------------------------------------------------
module lim_dec_countdown #(
    parameter int unsigned L0 = 10,
    parameter int unsigned L1 = 6,
    parameter int unsigned L2 = 10,
    parameter int unsigned L3 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start_stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic        done_q, done_d;

    logic [15:0] preset_clamped;
    logic [15:0] digits_dec;
    logic [3:0]  borrow;        // borrow[i] = digit i is decremented this tick
    logic        count_nonzero;
    logic        dec_zero;

`ifdef LIM_DEC_AUTO_RELOAD_EN
    logic [15:0] shadow_q, shadow_d;
`endif

    // The least significant digit is always the one the tick decrements.
    assign borrow[0] = 1'b1;

    // Per-digit clamp of the preset and one step of the borrow chain.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam int unsigned LIM = (gi == 0) ? L0 :
                                          (gi == 1) ? L1 :
                                          (gi == 2) ? L2 : L3;
            localparam logic [3:0] LIM_MAX = 4'(LIM - 1);
            localparam logic [4:0] LIM_W   = 5'(LIM);

            logic [3:0] cur;
            logic [3:0] pre;
            assign cur = digits_q[gi*4 +: 4];
            assign pre = preset[gi*4 +: 4];

            // Widened compare so a limit of 16 never clamps.
            assign preset_clamped[gi*4 +: 4] = ({1'b0, pre} >= LIM_W) ? LIM_MAX : pre;

            // A digit at 0 wraps to its maximum and passes the borrow upward.
            assign digits_dec[gi*4 +: 4] = borrow[gi] ?
                                           ((cur == 4'd0) ? LIM_MAX : (cur - 4'd1)) :
                                           cur;

            if (gi < 3) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
            end
        end
    endgenerate

    assign count_nonzero = (digits_q != 16'h0000);
    // Only meaningful when count_nonzero: 0000 itself is never decremented.
    assign dec_zero      = (digits_dec == 16'h0000);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            digits_q <= 16'h0000;
            done_q   <= 1'b0;
`ifdef LIM_DEC_AUTO_RELOAD_EN
            shadow_q <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            done_q   <= done_d;
`ifdef LIM_DEC_AUTO_RELOAD_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    // Next-state and datapath logic. load beats start_stop and tick.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        done_d   = 1'b0;
`ifdef LIM_DEC_AUTO_RELOAD_EN
        shadow_d = shadow_q;
`endif
        if (load) begin
            digits_d = preset_clamped;
            state_d  = IDLE;
`ifdef LIM_DEC_AUTO_RELOAD_EN
            shadow_d = preset_clamped;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_stop && count_nonzero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_d = PAUSED;
                    end
                    if (tick && count_nonzero) begin
                        if (dec_zero) begin
                            // Reaching zero takes precedence over a
                            // simultaneous pause request.
                            done_d = 1'b1;
`ifdef LIM_DEC_AUTO_RELOAD_EN
                            digits_d = shadow_q;
                            state_d  = RUN;
`else
                            digits_d = 16'h0000;
                            state_d  = EXPIRED;
`endif
                        end else begin
                            digits_d = digits_dec;
                        end
                    end
                end
                PAUSED: begin
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    // Only load or reset leaves this state.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state.
    always_comb begin
        digits  = digits_q;
        done    = done_q;
        running = (state_q == RUN);
        expired = (state_q == EXPIRED);
    end

endmodule

// File: tb/tb_lim_dec_countdown.sv
// -----------------------------------------------------------------------------
// tb_lim_dec_countdown
//
// Testbench for lim_dec_countdown using default limits (10/6/10/10). Each
// stimulus cycle pushes its expected post-edge outputs to a queue, and a
// checker pops and compares them on the following falling edge.
// Define LIM_DEC_AUTO_RELOAD_EN to exercise the auto-reload build.
// -----------------------------------------------------------------------------
module tb_lim_dec_countdown;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        start_stop = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        expired;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] dig;
        logic        run;
        logic        dn;
        logic        exp;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    lim_dec_countdown dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .preset     (preset),
        .start_stop (start_stop),
        .digits     (digits),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: outputs have settled after the preceding rising edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val({e.tag, ".digits"},  32'(digits),  32'(e.dig));
            check_val({e.tag, ".running"}, 32'(running), 32'(e.run));
            check_val({e.tag, ".done"},    32'(done),    32'(e.dn));
            check_val({e.tag, ".expired"}, 32'(expired), 32'(e.exp));
            $display("[TB] %-14s digits=%h running=%0b done=%0b expired=%0b",
                     e.tag, digits, running, done, expired);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic rst, input logic ld, input logic tk,
                        input logic ss, input logic [15:0] pre,
                        input logic [15:0] e_dig, input logic e_run,
                        input logic e_dn, input logic e_exp, input string tag);
        exp_t e;
        reset      = rst;
        load       = ld;
        tick       = tk;
        start_stop = ss;
        preset     = pre;
        @(posedge clk);
        #1;
        e.dig = e_dig; e.run = e_run; e.dn = e_dn; e.exp = e_exp; e.tag = tag;
        exp_q.push_back(e);
        reset = 1'b0; load = 1'b0; tick = 1'b0; start_stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset overrides a simultaneous load.
        step(1, 1, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, "reset0");
        step(1, 1, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, "reset1");

        // Borrow chain.
        step(0, 1, 0, 0, 16'h0102, 16'h0102, 0, 0, 0, "bc_load");
        step(0, 0, 1, 0, 16'h0000, 16'h0102, 0, 0, 0, "bc_idle_tick");
        step(0, 0, 0, 1, 16'h0000, 16'h0102, 1, 0, 0, "bc_start");
        step(0, 0, 1, 0, 16'h0000, 16'h0101, 1, 0, 0, "bc_t1");
        step(0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0, "bc_t2");
        step(0, 0, 1, 0, 16'h0000, 16'h0059, 1, 0, 0, "bc_t3");
        step(0, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0, "bc_hold");

        // Full ripple through every digit.
        step(0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, "rip_load");
        step(0, 0, 0, 1, 16'h0000, 16'h1000, 1, 0, 0, "rip_start");
        step(0, 0, 1, 0, 16'h0000, 16'h0959, 1, 0, 0, "rip_tick");

        // Expiry.
        step(0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, "ex_load");
        step(0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0, "ex_start");
        step(0, 0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0, "ex_t1");
`ifdef LIM_DEC_AUTO_RELOAD_EN
        step(0, 0, 1, 0, 16'h0000, 16'h0002, 1, 1, 0, "ar_reload");
        step(0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, "ar_after");
        step(0, 0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0, "ar_t1");
        step(0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0, "ar_pause");
        step(0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "ar_resume");
`else
        step(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1, "ex_t2");
        step(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, "ex_after");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, "ex_tick");
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1, "ex_ss");
`endif

        // Pause and resume; the load also leaves EXPIRED.
        step(0, 1, 0, 0, 16'h0030, 16'h0030, 0, 0, 0, "pr_load");
        step(0, 0, 0, 1, 16'h0000, 16'h0030, 1, 0, 0, "pr_start");
        step(0, 0, 0, 1, 16'h0000, 16'h0030, 0, 0, 0, "pr_pause");
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 0, 16'h0000, 16'h0030, 0, 0, 0, "pr_ptick");
        step(0, 0, 0, 1, 16'h0000, 16'h0030, 1, 0, 0, "pr_resume");
        step(0, 0, 1, 0, 16'h0000, 16'h0029, 1, 0, 0, "pr_tick");
        step(0, 0, 1, 1, 16'h0000, 16'h0028, 0, 0, 0, "pr_tick_ss");
        step(0, 0, 0, 1, 16'h0000, 16'h0028, 1, 0, 0, "pr_resume2");

        // Clamp and priority: load beats tick and start_stop in RUN.
        step(0, 1, 1, 1, 16'h9F7C, 16'h9959, 0, 0, 0, "cl_load");
        step(0, 0, 1, 0, 16'h0000, 16'h9959, 0, 0, 0, "cl_idle_tick");
        step(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "cl_zero");
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, "cl_zero_ss");

        // Reset while running.
        step(0, 1, 0, 0, 16'h0545, 16'h0545, 0, 0, 0, "rr_load");
        step(0, 0, 0, 1, 16'h0000, 16'h0545, 1, 0, 0, "rr_start");
        step(1, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, "rr_reset");

        repeat (2) @(negedge clk);
        check_val("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
